instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Front end that sits directly upstream of the mipscpu datapath/control block. It owns the PC, a loadable instruction memory and the branch/jump circuit. It presents one instruction word at a time on instrword and pulses newinstr once per instruction. It holds each word stable for a fixed number of cycles so the downstream multi-cycle control FSM can finish before the next instruction arrives.

Parameters:
IMEM_DEPTH, 64, number of 32-bit instruction words (power of 2); index = pc[log2(IMEM_DEPTH)+1:2], wraps modulo depth
INSTR_CYCLES, 6, clock cycles each instruction occupies, including its issue cycle; legal range >= 2
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
clock  in  1  single clock, all state changes on rising edge
reset  in  1  asynchronous, active-low; clears all state immediately on assertion
load_en  in  1  write strobe for instruction memory
load_addr  in  log2(IMEM_DEPTH)  word index for load
load_data  in  32  instruction word to load
start  in  1  begin execution at pc=0
zero  in  1  branch condition from the datapath (rs==rt); sampled only in the last HOLD cycle
instrword  out  32  current instruction to the CPU, stable from issue until the next issue
newinstr  out  1  one-cycle pulse, registered, coincident with the first cycle a new instrword is valid
pc  out  32  byte address of the current instruction
running  out  1  high in FETCH/HOLD
halted  out  1  high in HALT

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=0, instrword=0, newinstr=0, hold counter=0, running=0, halted=0. Instruction memory is NOT cleared, so a loaded program survives reset.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: start=1 at an edge sets pc<=0 and moves to FETCH.
- FETCH, one cycle. At the edge, word = imem[index(pc)].
  - If word==HALT_WORD: state<=HALT, newinstr stays 0, instrword unchanged.
  - Otherwise: instrword<=word, newinstr<=1, cnt<=INSTR_CYCLES-2, state<=HOLD.
- HOLD: newinstr<=0. While cnt!=0, cnt<=cnt-1.
- HOLD exit (cnt==0): compute the next pc, then state<=FETCH.
  - npc4 = pc+4.
  - opcode 6'd4 (beq) and zero=1: pc <= npc4 + (sext(imm16)<<2).
  - opcode 6'd2 (j): pc <= {npc4[31:28], instrword[25:0], 2'b00}.
  - Otherwise, including beq with zero=0: pc <= npc4.
- Issue period: exactly INSTR_CYCLES cycles between successive newinstr pulses.
- HALT: holds pc and instrword. start=1 sets pc<=0 and moves to FETCH (restart).
- Load: load_en writes imem[load_addr]<=load_data at the edge, only in IDLE or HALT. It is ignored in FETCH/HOLD.
- Load/fetch collision: load and start in the same cycle in IDLE means the write completes and the first FETCH occurs a cycle later, so it reads the new data.
- Address arithmetic is 32-bit with silent wrap-around. The memory index wraps modulo IMEM_DEPTH. Misaligned pc cannot occur (all updates are multiples of 4).
- start asserted while running is ignored.
- Async reset mid-HOLD aborts the instruction and returns to IDLE with outputs cleared as above.

Decomposition:
- Shared package/header holds:
  - opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_LW=35, OP_SW=43
  - HALT_WORD
  - state encodings IDLE=0, FETCH=1, HOLD=2, HALT=3
- One sub-module, instr_mem: synchronous write, combinational read, no reset.
- The FSM, hold counter and next-PC logic stay in the top block.

Test Plan:
- Reset and idle: reset=0 mid-run -> immediately pc=0, instrword=0, newinstr=0, running=0, halted=0. Then reset=1 with start=0 -> everything stays idle.
- Sequential run: load imem[0]=32'h00221820, imem[1]=32'h8C040004, imem[2]=HALT_WORD; pulse start.
  - newinstr pulses exactly 6 cycles apart at pc=0 and pc=4, with instrword matching each word.
  - At pc=8: no pulse, halted=1, pc stays 8.
- Branch taken/not: imem[0]=32'h10000003.
  - zero=1 in the last HOLD cycle -> next pc=16.
  - Rerun with zero=0 -> next pc=4.
  - zero toggled in earlier HOLD cycles has no effect.
- Jump and backward loop:
  - imem[0]=32'h08000005 -> next pc=20.
  - imem[2]=32'h1000FFFF at pc=8 with zero=1 -> pc stays 8; newinstr re-pulses every 6 cycles with the same word.
- Load gating: load_en with addr 0 and data 32'h12345678 during HOLD -> imem unchanged (verified by a later restart). The same write in HALT takes effect.
- Restart from HALT: start=1 in HALT -> halted=0, pc=0, first newinstr 1 cycle after FETCH entry. Program contents persist across an intervening reset.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end: opcodes, halt encoding,
// FSM state encoding and the branch offset helper.
package instr_fetch_unit_pkg;

   localparam logic [5:0]  OP_RTYPE  = 6'd0;
   localparam logic [5:0]  OP_J      = 6'd2;
   localparam logic [5:0]  OP_BEQ    = 6'd4;
   localparam logic [5:0]  OP_LW     = 6'd35;
   localparam logic [5:0]  OP_SW     = 6'd43;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } ifu_state_e;

   // Word offset of a beq immediate, sign-extended and scaled to bytes.
   function automatic logic [31:0] beq_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Load port, run control and instruction stream between the fetch unit and its
// environment (program loader + mipscpu datapath).
interface instr_fetch_unit_if #(parameter int AW = 6);
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          start;
   logic          zero;
   logic [31:0]   instrword;
   logic          newinstr;
   logic [31:0]   pc;
   logic          running;
   logic          halted;

   modport master (
      output load_en, load_addr, load_data, start, zero,
      input  instrword, newinstr, pc, running, halted
   );

   modport slave (
      input  load_en, load_addr, load_data, start, zero,
      output instrword, newinstr, pc, running, halted
   );
endinterface

// File: rtl/instr_fetch_unit_mem.sv
// Instruction store: synchronous write, combinational read, no reset so a
// loaded program survives the unit being reset.
module instr_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// PC, instruction memory and branch/jump logic feeding the mipscpu; issues one
// instruction every INSTR_CYCLES cycles until a halt word is fetched.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int IMEM_DEPTH   = 64,
   parameter int INSTR_CYCLES = 6
) (
   input logic              clock,
   input logic              reset,
   instr_fetch_unit_if.slave bus
);
   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int CW = $clog2(INSTR_CYCLES) + 1;

   ifu_state_e    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   instr_q, instr_d;
   logic          newinstr_q, newinstr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   word;
   logic [31:0]   npc4, next_pc;
   logic          mem_we;

   // Loader may only touch the program while nothing is being fetched.
   assign mem_we = bus.load_en && ((state_q == IDLE) || (state_q == HALT));

   instr_mem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
      .clock (clock),
      .we    (mem_we),
      .waddr (bus.load_addr),
      .wdata (bus.load_data),
      .raddr (pc_q[AW+1:2]),
      .rdata (word)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         newinstr_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         newinstr_q <= newinstr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = FETCH;
         FETCH:   state_d = (word == HALT_WORD) ? HALT : HOLD;
         HOLD:    if (cnt_q == '0) state_d = FETCH;
         HALT:    if (bus.start) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      npc4 = pc_q + 32'd4;
      if ((instr_q[31:26] == OP_BEQ) && bus.zero)
         next_pc = npc4 + beq_offset(instr_q[15:0]);
      else if (instr_q[31:26] == OP_J)
         next_pc = {npc4[31:28], instr_q[25:0], 2'b00};
      else
         next_pc = npc4;
   end

   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      newinstr_d = 1'b0;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE, HALT: if (bus.start) pc_d = '0;
         FETCH: begin
            if (word != HALT_WORD) begin
               instr_d    = word;
               newinstr_d = 1'b1;
               cnt_d      = CW'(INSTR_CYCLES - 2);
            end
         end
         HOLD: begin
            // zero is only meaningful here, in the last hold cycle.
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else             pc_d  = next_pc;
         end
         default: ;
      endcase
   end

   assign bus.instrword = instr_q;
   assign bus.newinstr  = newinstr_q;
   assign bus.pc        = pc_q;
   assign bus.running   = (state_q == FETCH) || (state_q == HOLD);
   assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequencing, branches, jumps, load gating,
// restart and reset behaviour.
module tb_instr_fetch_unit;
   localparam logic [31:0] HW = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   instr_fetch_unit_if #(.AW(6)) bus ();

   instr_fetch_unit #(.IMEM_DEPTH(64), .INSTR_CYCLES(6)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic load_word(input int a, input logic [31:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = 6'(a);
      bus.load_data = d;
      @(negedge clk);
      bus.load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_pulse(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.newinstr && n < budget);
   endtask

   task automatic wait_halt(input int budget, output logic ok);
      int n = 0;
      while (!bus.halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = bus.halted;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.pc !== 32'd0)        begin errors++; $display("FAIL rst_pc got=%h exp=0", bus.pc); end
      checks++; if (bus.instrword !== 32'd0) begin errors++; $display("FAIL rst_instr got=%h exp=0", bus.instrword); end
      checks++; if (bus.newinstr !== 1'b0)   begin errors++; $display("FAIL rst_newinstr got=%b exp=0", bus.newinstr); end
      checks++; if (bus.running !== 1'b0)    begin errors++; $display("FAIL rst_running got=%b exp=0", bus.running); end
      checks++; if (bus.halted !== 1'b0)     begin errors++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (bus.running !== 1'b0 || bus.newinstr !== 1'b0 || bus.pc !== 32'd0)
         begin errors++; $display("FAIL idle_stays got run=%b new=%b pc=%h exp 0/0/0", bus.running, bus.newinstr, bus.pc); end
      for (int i = 0; i < 64; i++) load_word(i, 32'd0);
   endtask

   task automatic test_sequential();
      int n; logic seen; logic ok;
      load_word(0, 32'h0022_1820);
      load_word(1, 32'h8C04_0004);
      load_word(2, HW);
      pulse_start();
      wait_pulse(20, n);
      checks++; if (n !== 1 || bus.pc !== 32'd0 || bus.instrword !== 32'h0022_1820)
         begin errors++; $display("FAIL seq_first got n=%0d pc=%h iw=%h exp n=1 pc=0 iw=00221820", n, bus.pc, bus.instrword); end
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL seq_running got=%b exp=1", bus.running); end
      wait_pulse(20, n);
      checks++; if (n !== 6 || bus.pc !== 32'd4 || bus.instrword !== 32'h8C04_0004)
         begin errors++; $display("FAIL seq_second got n=%0d pc=%h iw=%h exp n=6 pc=4 iw=8c040004", n, bus.pc, bus.instrword); end
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.newinstr) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL seq_halt_nopulse got=%b exp=0", seen); end
      checks++; if (bus.halted !== 1'b1 || bus.running !== 1'b0)
         begin errors++; $display("FAIL seq_halted got h=%b r=%b exp h=1 r=0", bus.halted, bus.running); end
      checks++; if (bus.pc !== 32'd8 || bus.instrword !== 32'h8C04_0004)
         begin errors++; $display("FAIL seq_halt_hold got pc=%h iw=%h exp pc=8 iw=8c040004", bus.pc, bus.instrword); end
      repeat (3) @(negedge clk);
      wait_halt(1, ok);
      checks++; if (ok !== 1'b1 || bus.pc !== 32'd8) begin errors++; $display("FAIL seq_halt_stay got h=%b pc=%h exp h=1 pc=8", ok, bus.pc); end
   endtask

   // zero driven 1 only in the cycle where mask bit k (1..4) is set; k=4 is the last HOLD cycle.
   task automatic run_beq(input logic [4:1] mask, input logic [31:0] exp_pc, input string nm);
      int n; logic ok;
      pulse_start();
      checks++; if (bus.halted !== 1'b0 || bus.pc !== 32'd0 || bus.running !== 1'b1)
         begin errors++; $display("FAIL %s_restart got h=%b pc=%h r=%b exp h=0 pc=0 r=1", nm, bus.halted, bus.pc, bus.running); end
      wait_pulse(20, n);
      checks++; if (n !== 1 || bus.instrword !== 32'h1000_0003)
         begin errors++; $display("FAIL %s_issue got n=%0d iw=%h exp n=1 iw=10000003", nm, n, bus.instrword); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.zero = mask[k];
      end
      @(negedge clk);
      bus.zero = 1'b0;
      checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL %s_pc got=%h exp=%h", nm, bus.pc, exp_pc); end
      wait_halt(20, ok);
      checks++; if (ok !== 1'b1 || bus.pc !== exp_pc)
         begin errors++; $display("FAIL %s_halt got h=%b pc=%h exp h=1 pc=%h", nm, ok, bus.pc, exp_pc); end
   endtask

   task automatic test_branch();
      load_word(0, 32'h1000_0003);
      load_word(1, HW);
      load_word(4, HW);
      run_beq(4'b1000, 32'd16, "beq_taken");
      run_beq(4'b0111, 32'd4,  "beq_not");
   endtask

   task automatic test_jump();
      int n; logic ok;
      load_word(0, 32'h0800_0005);
      load_word(5, HW);
      pulse_start();
      wait_pulse(20, n);
      repeat (5) @(negedge clk);
      checks++; if (bus.pc !== 32'd20) begin errors++; $display("FAIL jump_pc got=%h exp=14", bus.pc); end
      wait_halt(20, ok);
      checks++; if (ok !== 1'b1 || bus.pc !== 32'd20) begin errors++; $display("FAIL jump_halt got h=%b pc=%h exp h=1 pc=14", ok, bus.pc); end
   endtask

   task automatic test_loop_and_gating();
      int n; logic ok;
      load_word(0, 32'd0);
      load_word(1, 32'd0);
      load_word(2, 32'h1000_FFFF);
      load_word(3, HW);
      bus.zero = 1'b1;
      pulse_start();
      repeat (3) wait_pulse(20, n);
      checks++; if (bus.pc !== 32'd8 || bus.instrword !== 32'h1000_FFFF)
         begin errors++; $display("FAIL loop_enter got pc=%h iw=%h exp pc=8 iw=1000ffff", bus.pc, bus.instrword); end
      for (int r = 0; r < 2; r++) begin
         wait_pulse(20, n);
         checks++; if (n !== 6 || bus.pc !== 32'd8 || bus.instrword !== 32'h1000_FFFF)
            begin errors++; $display("FAIL loop_repulse%0d got n=%0d pc=%h iw=%h exp n=6 pc=8 iw=1000ffff", r, n, bus.pc, bus.instrword); end
      end
      load_word(0, 32'h1234_5678);
      bus.zero = 1'b0;
      wait_halt(20, ok);
      checks++; if (ok !== 1'b1 || bus.pc !== 32'd12) begin errors++; $display("FAIL loop_exit got h=%b pc=%h exp h=1 pc=c", ok, bus.pc); end
      pulse_start();
      wait_pulse(20, n);
      checks++; if (bus.instrword !== 32'd0) begin errors++; $display("FAIL load_gated got=%h exp=0", bus.instrword); end
      wait_halt(40, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gated_halt got=%b exp=1", ok); end
   endtask

   task automatic test_persist_and_collision();
      int n; logic ok;
      load_word(0, 32'h1234_5678);
      pulse_start();
      wait_pulse(20, n);
      checks++; if (bus.instrword !== 32'h1234_5678) begin errors++; $display("FAIL halt_load got=%h exp=12345678", bus.instrword); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.pc !== 32'd0 || bus.instrword !== 32'd0 || bus.newinstr !== 1'b0 || bus.running !== 1'b0 || bus.halted !== 1'b0)
         begin errors++; $display("FAIL midhold_reset got pc=%h iw=%h n=%b r=%b h=%b exp all 0", bus.pc, bus.instrword, bus.newinstr, bus.running, bus.halted); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.running !== 1'b0 || bus.pc !== 32'd0) begin errors++; $display("FAIL post_reset_idle got r=%b pc=%h exp r=0 pc=0", bus.running, bus.pc); end
      pulse_start();
      wait_pulse(20, n);
      checks++; if (n !== 1 || bus.instrword !== 32'h1234_5678)
         begin errors++; $display("FAIL persist got n=%0d iw=%h exp n=1 iw=12345678", n, bus.instrword); end
      wait_halt(40, ok);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_addr = 6'd0;
      bus.load_data = 32'h0022_1820;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.load_en = 1'b0;
      bus.start   = 1'b0;
      wait_pulse(20, n);
      checks++; if (n !== 1 || bus.instrword !== 32'h0022_1820 || bus.pc !== 32'd0)
         begin errors++; $display("FAIL collision got n=%0d iw=%h pc=%h exp n=1 iw=00221820 pc=0", n, bus.instrword, bus.pc); end
      wait_halt(40, ok);
      checks++; if (ok !== 1'b1 || bus.pc !== 32'd12) begin errors++; $display("FAIL final_halt got h=%b pc=%h exp h=1 pc=c", ok, bus.pc); end
   endtask

   initial begin
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.start     = 1'b0;
      bus.zero      = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_loop_and_gating();
      test_persist_and_collision();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
